// File: rtl/secuenciador_r.sv
// secuenciador_r: issues R-type words from a small program memory to the
// datapath, holds each for ESPERA cycles and counts sampled zero flags.
module secuenciador_r #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int ESPERA = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              carga_we,
    input  logic [ADDR_W-1:0] carga_addr,
    input  logic [31:0]       carga_dato,
    input  logic              inicio,
    input  logic [ADDR_W:0]   num_instr,
    input  logic              tr_zf,
    output logic [31:0]       instruccion_r,
    output logic              ocupado,
    output logic              fin,
    output logic              parada,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W:0]   cuenta_zf
);

    typedef enum logic [1:0] {REPOSO, EMITIR, FIN} estado_t;

    localparam int              CNT_W  = (ESPERA > 1) ? $clog2(ESPERA) : 1;
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(ESPERA - 1);

    logic [31:0]       mem [DEPTH];
    estado_t           estado, estado_sig;
    logic [31:0]       instr_sig;
    logic [ADDR_W-1:0] pc_sig;
    logic [ADDR_W:0]   n_q, n_sig, cuenta_sig, k;
    logic [CNT_W-1:0]  espera_q, espera_sig;
    logic              parada_sig;

    assign ocupado = (estado != REPOSO);
    assign fin     = (estado == FIN);
    assign k       = {1'b0, pc} + 1'b1;

    // Program memory load port; writes are dropped while a run is active.
    always_ff @(posedge clk) begin
        if (carga_we && estado == REPOSO)
            mem[carga_addr] <= carga_dato;
    end

    // Next-state and next-register computation for the sequencer.
    always_comb begin
        estado_sig = estado;
        instr_sig  = instruccion_r;
        pc_sig     = pc;
        n_sig      = n_q;
        cuenta_sig = cuenta_zf;
        espera_sig = espera_q;
        parada_sig = parada;
        case (estado)
            REPOSO: begin
                if (inicio) begin
                    n_sig      = num_instr;
                    cuenta_sig = '0;
                    parada_sig = 1'b0;
                    pc_sig     = '0;
                    espera_sig = '0;
                    if (num_instr == '0) begin
                        estado_sig = FIN;
                    end else if (mem[0][31:26] != 6'd0) begin
                        parada_sig = 1'b1;
                        estado_sig = FIN;
                    end else begin
                        instr_sig  = mem[0];
                        estado_sig = EMITIR;
                    end
                end
            end
            EMITIR: begin
                if (espera_q == ULTIMO) begin
                    if (tr_zf)
                        cuenta_sig = cuenta_zf + 1'b1;
                    // The bus is cleared on entry to FIN so the datapath
                    // never sees a stale or rejected word during the pulse.
                    if (k == n_q) begin
                        instr_sig  = '0;
                        estado_sig = FIN;
                    end else if (mem[k[ADDR_W-1:0]][31:26] != 6'd0) begin
                        instr_sig  = '0;
                        parada_sig = 1'b1;
                        estado_sig = FIN;
                    end else begin
                        pc_sig     = k[ADDR_W-1:0];
                        instr_sig  = mem[k[ADDR_W-1:0]];
                        espera_sig = '0;
                    end
                end else begin
                    espera_sig = espera_q + 1'b1;
                end
            end
            FIN: begin
                instr_sig  = '0;
                estado_sig = REPOSO;
            end
            default: begin
                instr_sig  = '0;
                estado_sig = REPOSO;
            end
        endcase
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado        <= REPOSO;
            instruccion_r <= '0;
            pc            <= '0;
            n_q           <= '0;
            cuenta_zf     <= '0;
            espera_q      <= '0;
            parada        <= 1'b0;
        end else begin
            estado        <= estado_sig;
            instruccion_r <= instr_sig;
            pc            <= pc_sig;
            n_q           <= n_sig;
            cuenta_zf     <= cuenta_sig;
            espera_q      <= espera_sig;
            parada        <= parada_sig;
        end
    end

endmodule

// File: tb/tb_secuenciador_r.sv
// tb_secuenciador_r: directed bench for secuenciador_r with ESPERA=4 and ESPERA=1.
module tb_secuenciador_r;

    localparam int ESPERA = 4;
    localparam logic [31:0] PROG [10] = '{
        32'h00A10000, 32'h00C45000, 32'h01272001, 32'h018A5801, 32'h01ED7002,
        32'h02508402, 32'h02B3B006, 32'h0316B806, 32'h0379A807, 32'h03DE7407
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        carga_we;
    logic [3:0]  carga_addr;
    logic [31:0] carga_dato;
    logic        inicio, inicio1;
    logic [4:0]  num_instr, num_instr1;
    logic        tr_zf, tr_zf1;
    logic [31:0] instruccion_r, instruccion_r1;
    logic        ocupado, ocupado1, fin, fin1, parada, parada1;
    logic [3:0]  pc, pc1;
    logic [4:0]  cuenta_zf, cuenta_zf1;

    int total   = 0;
    int pasados = 0;

    always #5 clk = ~clk;

    // Datapath stub: zero result for program words 2 and 5 only.
    assign tr_zf  = (instruccion_r == PROG[2]) || (instruccion_r == PROG[5]);
    assign tr_zf1 = 1'b1;

    secuenciador_r #(.DEPTH(16), .ADDR_W(4), .ESPERA(ESPERA)) dut (
        .clk(clk), .rst_n(rst_n), .carga_we(carga_we), .carga_addr(carga_addr),
        .carga_dato(carga_dato), .inicio(inicio), .num_instr(num_instr),
        .tr_zf(tr_zf), .instruccion_r(instruccion_r), .ocupado(ocupado),
        .fin(fin), .parada(parada), .pc(pc), .cuenta_zf(cuenta_zf)
    );

    secuenciador_r #(.DEPTH(16), .ADDR_W(4), .ESPERA(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .carga_we(carga_we), .carga_addr(carga_addr),
        .carga_dato(carga_dato), .inicio(inicio1), .num_instr(num_instr1),
        .tr_zf(tr_zf1), .instruccion_r(instruccion_r1), .ocupado(ocupado1),
        .fin(fin1), .parada(parada1), .pc(pc1), .cuenta_zf(cuenta_zf1)
    );

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        else
            pasados++;
    endtask

    task automatic paso();
        @(posedge clk);
        #1;
    endtask

    task automatic cargar(input int addr, input logic [31:0] dato);
        carga_we   = 1'b1;
        carga_addr = 4'(addr);
        carga_dato = dato;
        paso();
        carga_we   = 1'b0;
    endtask

    // One run on the ESPERA=4 instance; optionally disturbs it mid-run with
    // a write to address 5 and a second start pulse, both of which must be ignored.
    task automatic correr(input int n, input int emitidas, input bit halt,
                          input int zf, input bit molestar);
        num_instr = 5'(n);
        inicio    = 1'b1;
        paso();
        inicio    = 1'b0;
        comprobar("ocupado_start", ocupado, 1);
        for (int i = 0; i < emitidas; i++) begin
            for (int c = 0; c < ESPERA; c++) begin
                comprobar($sformatf("instr_w%0d_c%0d", i, c), instruccion_r, PROG[i]);
                if (molestar && i == 1 && c == 0) begin
                    carga_we   = 1'b1;
                    carga_addr = 4'd5;
                    carga_dato = 32'hFC000000;
                    inicio     = 1'b1;
                    num_instr  = 5'd3;
                end
                paso();
                carga_we = 1'b0;
                inicio   = 1'b0;
            end
        end
        comprobar("fin_pulse", fin, 1);
        comprobar("parada", parada, 32'(halt));
        comprobar("cuenta_zf", cuenta_zf, zf);
        comprobar("pc_end", pc, (emitidas > 0) ? emitidas - 1 : 0);
        if (n == 0)
            comprobar("instr_n0", instruccion_r, 0);
        if (halt)
            comprobar("halt_word_hidden", instruccion_r == 32'hFC000000, 0);
        paso();
        comprobar("ocupado_after", ocupado, 0);
        comprobar("fin_after", fin, 0);
        comprobar("parada_sticky", parada, 32'(halt));
        comprobar("instr_idle", instruccion_r, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        carga_we   = 1'b0;
        carga_addr = '0;
        carga_dato = '0;
        inicio     = 1'b0;
        inicio1    = 1'b0;
        num_instr  = '0;
        num_instr1 = '0;
        paso();
        paso();
        comprobar("rst_instr", instruccion_r, 0);
        comprobar("rst_ocupado", ocupado, 0);
        comprobar("rst_fin", fin, 0);
        comprobar("rst_parada", parada, 0);
        comprobar("rst_pc", pc, 0);
        comprobar("rst_cuenta", cuenta_zf, 0);
        rst_n = 1'b1;
        paso();

        for (int i = 0; i < 10; i++)
            cargar(i, PROG[i]);

        // Full program, zero flags on words 2 and 5.
        correr(10, 10, 1'b0, 2, 1'b0);
        // Empty run.
        correr(0, 0, 1'b0, 0, 1'b0);
        // Halt before word 3.
        cargar(3, 32'hFC000000);
        correr(10, 3, 1'b1, 1, 1'b0);
        cargar(3, PROG[3]);
        // Mid-run write and start are ignored.
        correr(10, 10, 1'b0, 2, 1'b1);
        // A write after the run does land: the halting word now stops at 5.
        cargar(5, 32'hFC000000);
        correr(10, 5, 1'b1, 1, 1'b0);
        cargar(5, PROG[5]);

        // Reset during word 4, then replay.
        num_instr = 5'd10;
        inicio    = 1'b1;
        paso();
        inicio    = 1'b0;
        repeat (16) paso();
        comprobar("pre_rst_instr", instruccion_r, PROG[4]);
        comprobar("pre_rst_pc", pc, 4);
        comprobar("pre_rst_cuenta", cuenta_zf, 1);
        rst_n = 1'b0;
        #1;
        comprobar("midrst_instr", instruccion_r, 0);
        comprobar("midrst_ocupado", ocupado, 0);
        comprobar("midrst_fin", fin, 0);
        comprobar("midrst_parada", parada, 0);
        comprobar("midrst_pc", pc, 0);
        comprobar("midrst_cuenta", cuenta_zf, 0);
        paso();
        rst_n = 1'b1;
        paso();
        correr(10, 10, 1'b0, 2, 1'b0);

        // ESPERA=1 instance: 16 back-to-back words with tr_zf held high.
        for (int i = 0; i < 16; i++)
            cargar(i, 32'(i * 7 + 1));
        num_instr1 = 5'd16;
        inicio1    = 1'b1;
        paso();
        inicio1    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            comprobar($sformatf("e1_instr_%0d", i), instruccion_r1, 32'(i * 7 + 1));
            comprobar($sformatf("e1_pc_%0d", i), pc1, i);
            comprobar($sformatf("e1_cuenta_%0d", i), cuenta_zf1, i);
            comprobar($sformatf("e1_ocupado_%0d", i), ocupado1, 1);
            paso();
        end
        comprobar("e1_fin", fin1, 1);
        comprobar("e1_cuenta_end", cuenta_zf1, 16);
        comprobar("e1_pc_end", pc1, 15);
        comprobar("e1_parada", parada1, 0);
        paso();
        comprobar("e1_ocupado_after", ocupado1, 0);
        comprobar("e1_cuenta_hold", cuenta_zf1, 16);

        $display("%0d/%0d checks passed", pasados, total);
        $finish;
    end

endmodule
